// File: rtl/sha3_work_dispatcher.sv
// Work dispatcher for a SHA3 nonce scanner: launches batches, advances the nonce
// base between batches and reports found / batch-limit / nonce-wrap / abort results.
module sha3_work_dispatcher #(
  parameter int unsigned PROPER     = 1,
  parameter int unsigned NONCE_WORD = 19,
  localparam int unsigned BW        = (PROPER != 0) ? 20 : 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             job_valid,
  output logic             job_ready,
  input  logic [32*BW-1:0] job_blob,
  input  logic [63:0]      job_threshold,
  input  logic [31:0]      job_batches,
  input  logic             abort,
  output logic             scn_start,
  output logic [63:0]      scn_threshold,
  output logic [32*BW-1:0] scn_blobby,
  input  logic             scn_ready,
  input  logic             scn_dispatching,
  input  logic             scn_evaluating,
  input  logic             scn_found,
  input  logic [31:0]      scn_nonce,
  input  logic [64*25-1:0] scn_hash,
  input  logic [31:0]      scn_scan_count,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [1:0]       res_status,
  output logic [31:0]      res_nonce,
  output logic [64*25-1:0] res_hash,
  output logic [31:0]      res_batches,
  output logic             busy
);

  typedef enum logic [2:0] {IDLE, LAUNCH, WAIT_ACCEPT, WAIT_DONE, REPORT} state_e;
  typedef enum logic [1:0] {ST_FOUND = 2'b00, ST_LIMIT = 2'b01, ST_WRAP = 2'b10, ST_ABORT = 2'b11} status_e;

  state_e           state_q, state_d;
  status_e          status_q, status_d;
  logic [32*BW-1:0] blob_q;
  logic [63:0]      thr_q;
  logic [31:0]      limit_q;
  logic [31:0]      batch_cnt;
  logic [31:0]      batch_inc;
  logic             abort_q;
  logic [32:0]      nonce_sum;
  logic             accept, batch_done, to_report, capture, advance, set_abort;

  assign batch_inc = batch_cnt + 32'd1;
  assign nonce_sum = {1'b0, blob_q[32*NONCE_WORD +: 32]} + {1'b0, scn_scan_count};

  assign scn_blobby    = blob_q;
  assign scn_threshold = thr_q;
  assign res_valid     = (state_q == REPORT);
  assign busy          = (state_q != IDLE);
  assign res_status    = status_q;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    status_d   = ST_FOUND;
    job_ready  = 1'b0;
    scn_start  = 1'b0;
    accept     = 1'b0;
    batch_done = 1'b0;
    to_report  = 1'b0;
    capture    = 1'b0;
    advance    = 1'b0;
    set_abort  = 1'b0;
    unique case (state_q)
      IDLE: begin
        job_ready = !rst;
        if (job_valid && !rst) begin
          accept  = 1'b1;
          state_d = LAUNCH;
        end
      end
      LAUNCH: begin
        // Abort before launch wins over a ready scanner: no start pulse is issued.
        if (abort) begin
          set_abort = 1'b1;
          to_report = 1'b1;
          status_d  = ST_ABORT;
          state_d   = REPORT;
        end else if (scn_ready) begin
          scn_start = !rst;
          state_d   = WAIT_ACCEPT;
        end
      end
      WAIT_ACCEPT: begin
        set_abort = abort;
        if (!scn_ready) state_d = WAIT_DONE;
      end
      WAIT_DONE: begin
        set_abort = abort;
        if (scn_ready && !scn_dispatching && !scn_evaluating) begin
          batch_done = 1'b1;
          to_report  = 1'b1;
          state_d    = REPORT;
          if (scn_found) begin
            capture  = 1'b1;
            status_d = ST_FOUND;
          end else if (abort_q || abort) begin
            status_d = ST_ABORT;
          end else if (limit_q != '0 && batch_inc == limit_q) begin
            status_d = ST_LIMIT;
          end else if (nonce_sum[32]) begin
            status_d = ST_WRAP;
          end else begin
            to_report = 1'b0;
            advance   = 1'b1;
            state_d   = LAUNCH;
          end
        end
      end
      REPORT: begin
        if (res_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      blob_q      <= '0;
      thr_q       <= '0;
      limit_q     <= '0;
      batch_cnt   <= '0;
      abort_q     <= 1'b0;
      status_q    <= ST_FOUND;
      res_nonce   <= '0;
      res_hash    <= '0;
      res_batches <= '0;
    end else begin
      if (accept) begin
        blob_q    <= job_blob;
        thr_q     <= job_threshold;
        limit_q   <= job_batches;
        batch_cnt <= '0;
        abort_q   <= 1'b0;
      end
      if (set_abort)  abort_q   <= 1'b1;
      if (batch_done) batch_cnt <= batch_inc;
      if (advance)    blob_q[32*NONCE_WORD +: 32] <= nonce_sum[31:0];
      if (capture) begin
        res_nonce <= scn_nonce;
        res_hash  <= scn_hash;
      end
      if (to_report) begin
        status_q    <= status_d;
        res_batches <= batch_done ? batch_inc : batch_cnt;
      end
    end
  end

endmodule

// File: tb/tb_sha3_work_dispatcher.sv
// Bench for sha3_work_dispatcher: behavioural scanner model, table of jobs with a
// result scoreboard, plus hand-written launch-abort and mid-batch reset sequences.
module tb_sha3_work_dispatcher;
  localparam int unsigned BW = 20;

  logic             clk, rst, job_valid, job_ready, abort, scn_start;
  logic [32*BW-1:0] job_blob, scn_blobby;
  logic [63:0]      job_threshold, scn_threshold;
  logic [31:0]      job_batches, scn_nonce, scn_scan_count, res_nonce, res_batches;
  logic             scn_ready, scn_dispatching, scn_evaluating, scn_found;
  logic [64*25-1:0] scn_hash, res_hash;
  logic             res_valid, res_ready, busy;
  logic [1:0]       res_status;

  logic scn_ready_m, stall, abort_m, abort_h;
  assign scn_ready = scn_ready_m & ~stall;
  assign abort     = abort_m | abort_h;

  typedef struct {
    logic [31:0] n19, nbat, scan;
    int          find_b;
    logic [31:0] find_n;
    int          abort_b;
    bit          launch_abort;
    int          hold;
    logic [1:0]  st;
    int          starts;
    logic [31:0] rbat;
  } row_t;

  typedef struct {
    logic [1:0]       st;
    logic [31:0]      nonce, rbat;
    logic [64*25-1:0] hash;
    int               starts;
  } exp_t;

  logic [31:0]      exp_nonce_q[$];
  exp_t             exp_res_q[$];
  int               checks = 0, errors = 0, pulse_cnt = 0, job_seq = 0;
  int               cur_find_b = 0, cur_abort_b = 0;
  logic [31:0]      cur_find_n = '0, last_nonce = '0;
  logic [63:0]      cur_thr = '0;
  logic [64*25-1:0] last_hash = '0;
  bit               no_hold_check = 1'b0;

  sha3_work_dispatcher #(.PROPER(1), .NONCE_WORD(19)) dut (
    .clk(clk), .rst(rst), .job_valid(job_valid), .job_ready(job_ready),
    .job_blob(job_blob), .job_threshold(job_threshold), .job_batches(job_batches),
    .abort(abort), .scn_start(scn_start), .scn_threshold(scn_threshold),
    .scn_blobby(scn_blobby), .scn_ready(scn_ready), .scn_dispatching(scn_dispatching),
    .scn_evaluating(scn_evaluating), .scn_found(scn_found), .scn_nonce(scn_nonce),
    .scn_hash(scn_hash), .scn_scan_count(scn_scan_count), .res_valid(res_valid),
    .res_ready(res_ready), .res_status(res_status), .res_nonce(res_nonce),
    .res_hash(res_hash), .res_batches(res_batches), .busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1);
  end

  function automatic logic [64*25-1:0] hash_of(input logic [31:0] n);
    logic [64*25-1:0] h;
    for (int i = 0; i < 25; i++) h[64*i +: 64] = {n ^ 32'(i), 32'hA5A5_0000 + 32'(i)};
    return h;
  endfunction

  function automatic logic [32*BW-1:0] make_blob(input logic [31:0] n19);
    logic [32*BW-1:0] b;
    for (int i = 0; i < int'(BW); i++) b[32*i +: 32] = (i == 19) ? n19 : 32'h1111_0000 + 32'(i);
    return b;
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h", name, got, want);
    end
  endtask

  task automatic chk_hash(input string name, input logic [64*25-1:0] got, input logic [64*25-1:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got lane0 %h lane24 %h, want lane0 %h lane24 %h",
               name, got[63:0], got[64*24 +: 64], want[63:0], want[64*24 +: 64]);
    end
  endtask

  // start-pulse counter: a pulse held for two cycles counts twice
  initial begin
    forever begin
      @(negedge clk);
      if (scn_start === 1'b1) pulse_cnt++;
    end
  end

  // behavioural scanner: drops ready after a start, dispatches, evaluates, then reports
  initial begin
    int seen_seq, batch_idx;
    seen_seq = -1; batch_idx = 0;
    scn_ready_m = 1'b1; scn_dispatching = 1'b0; scn_evaluating = 1'b0; scn_found = 1'b0;
    scn_nonce = '0; scn_hash = '0; abort_m = 1'b0;
    forever begin
      @(negedge clk);
      if (scn_start === 1'b1) begin
        if (job_seq != seen_seq) begin
          seen_seq  = job_seq;
          batch_idx = 0;
        end
        batch_idx++;
        if (exp_nonce_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL scn_start: unexpected start, nonce word %h", scn_blobby[32*19 +: 32]);
        end else begin
          chk("scn_blobby nonce word", scn_blobby[32*19 +: 32], exp_nonce_q.pop_front());
        end
        @(posedge clk); #1;
        scn_ready_m = 1'b0; scn_dispatching = 1'b1; scn_found = 1'b0;
        for (int c = 1; c <= 8; c++) begin
          @(posedge clk); #1;
          if (c == 2 && batch_idx == cur_abort_b) abort_m = 1'b1;
          if (c == 3) abort_m = 1'b0;
          if (c == 4) begin scn_dispatching = 1'b0; scn_evaluating = 1'b1; end
          if (c == 1 || (c == 8 && !no_hold_check)) begin
            chk("scn_threshold held", scn_threshold, cur_thr);
            chk("scn_blobby word0 held", scn_blobby[31:0], 32'h1111_0000);
          end
        end
        scn_evaluating = 1'b0; scn_ready_m = 1'b1;
        if (batch_idx == cur_find_b) begin
          scn_found = 1'b1;
          scn_nonce = cur_find_n;
          scn_hash  = hash_of(cur_find_n);
        end
      end
    end
  end

  task automatic drive_job(input logic [31:0] n19, input logic [31:0] nbat, input logic [31:0] scan);
    @(posedge clk); #1;
    job_blob       = make_blob(n19);
    job_threshold  = {~n19, n19};
    cur_thr        = {~n19, n19};
    job_batches    = nbat;
    scn_scan_count = scan;
    job_valid      = 1'b1;
    @(posedge clk); #1;
    job_valid = 1'b0;
  endtask

  task automatic run_job(input row_t r);
    exp_t        e, g;
    logic [31:0] n;
    int          p0, t;
    cur_find_b = r.find_b; cur_find_n = r.find_n; cur_abort_b = r.abort_b;
    job_seq++;
    n = r.n19;
    for (int i = 0; i < r.starts; i++) begin
      exp_nonce_q.push_back(n);
      n = n + r.scan;
    end
    if (r.st == 2'b00) begin
      last_nonce = r.find_n;
      last_hash  = hash_of(r.find_n);
    end
    e.st = r.st; e.nonce = last_nonce; e.rbat = r.rbat; e.hash = last_hash; e.starts = r.starts;
    exp_res_q.push_back(e);
    p0 = pulse_cnt;
    if (r.launch_abort) stall = 1'b1;
    drive_job(r.n19, r.nbat, r.scan);
    if (r.launch_abort) begin
      @(posedge clk); #1 abort_h = 1'b1;
      @(posedge clk); #1 abort_h = 1'b0;
      stall = 1'b0;
    end
    t = 0;
    @(negedge clk);
    while (res_valid !== 1'b1 && t < 3000) begin
      @(negedge clk);
      t++;
    end
    chk("res_valid rises", res_valid, 1);
    g = exp_res_q.pop_front();
    chk("res_status", res_status, g.st);
    chk("res_nonce", res_nonce, g.nonce);
    chk("res_batches", res_batches, g.rbat);
    chk_hash("res_hash", res_hash, g.hash);
    chk("busy in REPORT", busy, 1);
    chk("job_ready in REPORT", job_ready, 0);
    for (int c = 0; c < r.hold; c++) begin
      @(negedge clk);
      chk("held res_valid", res_valid, 1);
      chk("held res_status", res_status, g.st);
      chk("held res_nonce", res_nonce, g.nonce);
      chk("held res_batches", res_batches, g.rbat);
      chk("held job_ready", job_ready, 0);
    end
    @(posedge clk); #1 res_ready = 1'b1;
    @(posedge clk); #1 res_ready = 1'b0;
    @(negedge clk);
    chk("res_valid after consume", res_valid, 0);
    chk("busy after consume", busy, 0);
    chk("job_ready after consume", job_ready, 1);
    chk("start pulse count", 64'(pulse_cnt - p0), 64'(g.starts));
  endtask

  initial begin
    row_t rows [9];
    row_t post;
    int   p0, t;
    rows[0] = '{32'h0,        32'd0, 32'h100, 3, 32'h250,  0, 1'b0, 10, 2'b00, 3, 32'd3};
    rows[1] = '{32'h1000,     32'd2, 32'h100, 0, 32'h0,    0, 1'b0, 0,  2'b01, 2, 32'd2};
    rows[2] = '{32'hFFFFFF00, 32'd0, 32'h100, 0, 32'h0,    0, 1'b0, 0,  2'b10, 1, 32'd1};
    rows[3] = '{32'h40,       32'd0, 32'h100, 1, 32'h77,   1, 1'b0, 0,  2'b00, 1, 32'd1};
    rows[4] = '{32'h40,       32'd0, 32'h100, 0, 32'h0,    1, 1'b0, 0,  2'b11, 1, 32'd1};
    rows[5] = '{32'h80,       32'd1, 32'h100, 1, 32'h99,   0, 1'b0, 0,  2'b00, 1, 32'd1};
    rows[6] = '{32'hFFFFFE00, 32'd2, 32'h100, 0, 32'h0,    0, 1'b0, 0,  2'b01, 2, 32'd2};
    rows[7] = '{32'h7000,     32'd0, 32'h20,  4, 32'h7065, 0, 1'b0, 0,  2'b00, 4, 32'd4};
    rows[8] = '{32'h300,      32'd0, 32'h100, 0, 32'h0,    0, 1'b1, 0,  2'b11, 0, 32'd0};
    post    = '{32'h10,       32'd1, 32'h100, 0, 32'h0,    0, 1'b0, 0,  2'b01, 1, 32'd1};

    rst = 1'b1; job_valid = 1'b0; res_ready = 1'b0; stall = 1'b0; abort_h = 1'b0;
    job_blob = '0; job_threshold = '0; job_batches = '0; scn_scan_count = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("job_ready during reset", job_ready, 0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("reset job_ready", job_ready, 1);
    chk("reset scn_start", scn_start, 0);
    chk("reset res_valid", res_valid, 0);
    chk("reset res_status", res_status, 0);
    chk("reset res_nonce", res_nonce, 0);
    chk("reset res_batches", res_batches, 0);
    chk("reset busy", busy, 0);
    chk("reset scn_threshold", scn_threshold, 0);
    chk("reset blob nonce word", scn_blobby[32*19 +: 32], 0);
    chk_hash("reset res_hash", res_hash, '0);

    for (int i = 0; i < 9; i++) run_job(rows[i]);

    // reset while the scanner batch is in flight
    cur_find_b = 0; cur_abort_b = 0;
    job_seq++;
    exp_nonce_q.push_back(32'h500);
    p0 = pulse_cnt;
    drive_job(32'h500, 32'd0, 32'h100);
    t = 0;
    while (pulse_cnt == p0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("start before reset", 64'(pulse_cnt - p0), 1);
    no_hold_check = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("job_ready in mid-batch reset", job_ready, 0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("post-reset busy", busy, 0);
    chk("post-reset res_valid", res_valid, 0);
    chk("post-reset job_ready", job_ready, 1);
    chk("post-reset res_batches", res_batches, 0);
    last_nonce = '0;
    last_hash  = '0;
    p0 = pulse_cnt;
    repeat (15) @(negedge clk);
    chk("no start after reset", 64'(pulse_cnt - p0), 0);
    chk("idle after scanner finishes", busy, 0);
    no_hold_check = 1'b0;
    run_job(post);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sha3_work_dispatcher.md
SHA3_WORK_DISPATCHER -- requirements
Module: sha3_work_dispatcher

Interface
REQ-001 SHALL have parameter PROPER, default 1: blob width is 20 words when 1, 24 when 0; the width is BW below.
REQ-002 SHALL have parameter NONCE_WORD, default 19: the index of the blob word holding the nonce base.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port job_valid, input, 1 bit: host offers a job.
REQ-006 SHALL have port job_ready, output, 1 bit: the dispatcher accepts a job.
REQ-007 SHALL have port job_blob, input, 32 bits x BW: the block template.
REQ-008 SHALL have port job_threshold, input, 64 bits: the difficulty threshold.
REQ-009 SHALL have port job_batches, input, 32 bits: maximum scanner batches; 0 means unlimited.
REQ-010 SHALL have port abort, input, 1 bit: request to stop the current job.
REQ-011 SHALL have port scn_start, output, 1 bit: one-cycle start pulse to the scanner.
REQ-012 SHALL have port scn_threshold, output, 64 bits: threshold driven to the scanner.
REQ-013 SHALL have port scn_blobby, output, 32 bits x BW: blob driven to the scanner.
REQ-014 SHALL have ports scn_ready, scn_dispatching, scn_evaluating, scn_found, inputs, 1 bit each: scanner status.
REQ-015 SHALL have port scn_nonce, input, 32 bits: winning nonce from the scanner.
REQ-016 SHALL have port scn_hash, input, 64 bits x 25: winning hash from the scanner.
REQ-017 SHALL have port scn_scan_count, input, 32 bits: nonces tested per scanner batch.
REQ-018 SHALL have port res_valid, output, 1 bit: a result is held.
REQ-019 SHALL have port res_ready, input, 1 bit: host consumes the result.
REQ-020 SHALL have port res_status, output, 2 bits: 00 found, 01 batch limit reached, 10 nonce space wrapped, 11 aborted.
REQ-021 SHALL have port res_nonce, output, 32 bits: winning nonce.
REQ-022 SHALL have port res_hash, output, 64 bits x 25: winning hash.
REQ-023 SHALL have port res_batches, output, 32 bits: number of batches completed for this job.
REQ-024 SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.

Function
REQ-025 SHALL implement the states IDLE, LAUNCH, WAIT_ACCEPT, WAIT_DONE and REPORT.
REQ-026 SHALL drive job_ready=1 only in IDLE.
REQ-027 SHALL, on job_valid&job_ready, latch blob, threshold and batches, clear the batch counter, clear the abort flag, and go to LAUNCH.
REQ-028 SHALL drive scn_blobby and scn_threshold from the latched registers, holding them stable from LAUNCH through WAIT_DONE.
REQ-029 SHALL, in LAUNCH with scn_ready=1, pulse scn_start for exactly 1 cycle and go to WAIT_ACCEPT; with scn_ready=0 it SHALL wait.
REQ-030 SHALL, in WAIT_ACCEPT, go to WAIT_DONE when scn_ready=0.
REQ-031 SHALL, in WAIT_DONE, treat the batch as complete when scn_ready=1, scn_dispatching=0 and scn_evaluating=0.
REQ-032 SHALL, on batch completion, increment the batch counter with wrap at 2^32.
REQ-033 SHALL, on batch completion with scn_found=1, capture scn_nonce and scn_hash and go to REPORT with status 00; found has priority over all other exits.
REQ-034 SHALL, otherwise, go to REPORT with status 11 if the abort flag is set.
REQ-035 SHALL, otherwise, go to REPORT with status 01 if job_batches!=0 and the new counter equals job_batches.
REQ-036 SHALL, otherwise, compute blob[NONCE_WORD] + scn_scan_count in 33 bits; on carry-out it SHALL go to REPORT with status 10, else write the 32-bit sum back to the nonce word and return to LAUNCH.
REQ-037 SHALL set the abort flag when abort=1 in LAUNCH, WAIT_ACCEPT or WAIT_DONE; in LAUNCH it SHALL go directly to REPORT with status 11 and no start pulse, and in the other states it SHALL exit at the end of the batch.
REQ-038 SHALL ignore abort in IDLE and REPORT.
REQ-039 SHALL, in REPORT, hold res_valid=1 with all res_* stable until res_ready=1, then return to IDLE in the next cycle.
REQ-040 SHALL leave res_nonce and res_hash unchanged from the previous capture when the status is not 00.
REQ-041 SHALL have res_batches equal the batch counter at the REPORT entry.

Reset
REQ-042 SHALL, on rst=1 from any state, go to IDLE in the next cycle.
REQ-043 SHALL reset the outputs to: job_ready=0 during the reset cycle, then 1; scn_start=0; res_valid=0; res_status=00; res_nonce=0; res_hash=0; res_batches=0; busy=0; abort flag=0.
REQ-044 SHALL reset the latched blob and threshold to 0.
REQ-045 SHALL NOT resume a scanner batch that is in flight at reset; scanner outputs SHALL be ignored until a new job is accepted.

Verification
REQ-046 SHALL be verified by: job with blob[19]=0x00000000, batches=0, scan_count=0x100, and the scanner model finding on its 3rd batch with nonce 0x250 -> exactly 3 scn_start pulses, scn_blobby[19] sequence 0x0/0x100/0x200, res_status=00, res_nonce=0x250, res_batches=3.
REQ-047 SHALL be verified by: batches=2 and never found -> res_status=01, res_batches=2, exactly 2 start pulses.
REQ-048 SHALL be verified by: blob[19]=0xFFFFFF00, scan_count=0x100, not found -> 1 batch, res_status=10, res_batches=1.
REQ-049 SHALL be verified by: abort asserted 2 cycles into WAIT_DONE, with the batch finding a result -> res_status=00; the same stimulus without a find -> res_status=11, with no further start pulse.
REQ-050 SHALL be verified by: res_ready held 0 for 10 cycles -> res_valid and all res_* stable, and job_ready=0 throughout.
REQ-051 SHALL be verified by: rst pulsed during WAIT_DONE -> IDLE next cycle, res_valid=0, busy=0, and a subsequent job running normally.
